// File: rtl/rvee_axil_pkg.sv
// Shared definitions for the AXI4-Lite RAM responder: response codes and
// the write/read channel state encodings.
package rvee_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_AW,
        W_HAVE_W,
        W_RESP
    } w_state_e;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } r_state_e;

endpackage : rvee_axil_pkg

// File: rtl/rvee_axil_ram_if.sv
// AXI4-Lite bus bundle (five channels) with master and slave views.
interface rvee_axil_ram_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);

    logic                  awvalid;
    logic                  awready;
    logic [AWIDTH-1:0]     awaddr;
    logic [2:0]            awprot;

    logic                  wvalid;
    logic                  wready;
    logic [DWIDTH-1:0]     wdata;
    logic [DWIDTH/8-1:0]   wstrb;

    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;

    logic                  arvalid;
    logic                  arready;
    logic [AWIDTH-1:0]     araddr;
    logic [2:0]            arprot;

    logic                  rvalid;
    logic                  rready;
    logic [DWIDTH-1:0]     rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, awprot,
        input  awready,
        output wvalid, wdata, wstrb,
        input  wready,
        input  bvalid, bresp,
        output bready,
        output arvalid, araddr, arprot,
        input  arready,
        input  rvalid, rdata, rresp,
        output rready
    );

    modport slave (
        input  awvalid, awaddr, awprot,
        output awready,
        input  wvalid, wdata, wstrb,
        output wready,
        output bvalid, bresp,
        input  bready,
        input  arvalid, araddr, arprot,
        output arready,
        output rvalid, rdata, rresp,
        input  rready
    );

endinterface : rvee_axil_ram_if

// File: rtl/rvee_ram_2p.sv
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// A same-cycle read and write to one word returns the old contents.
module rvee_ram_2p #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned DEPTH  = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [DWIDTH-1:0]          wdata,
    input  logic [DWIDTH/8-1:0]        wstrb,
    input  logic                       re,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [DWIDTH-1:0]          rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // NOTE: the array has no reset branch so it maps onto block RAM; only the read register is cleared.
    always_ff @(posedge clk) begin
        for (int b = 0; b < DWIDTH / 8; b++) begin
            if (we && wstrb[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule : rvee_ram_2p

// File: rtl/rvee_axil_ram.sv
// AXI4-Lite RAM responder with independent read and write channels.
// Define RVEE_AXIL_RAM_ERR_EN to answer out-of-window accesses with SLVERR instead of wrapping.
module rvee_axil_ram
    import rvee_axil_pkg::*;
#(
    parameter int unsigned       AWIDTH = 32,
    parameter int unsigned       DWIDTH = 32,
    parameter int unsigned       DEPTH  = 1024,
    parameter logic [AWIDTH-1:0] BASE   = '0
) (
    input logic            clk,
    input logic            rst,
    rvee_axil_ram_if.slave bus
);

    localparam int unsigned STRB_W    = DWIDTH / 8;
    localparam int unsigned LANE_BITS = $clog2(STRB_W);
    localparam int unsigned IDX_BITS  = $clog2(DEPTH);

    function automatic logic [IDX_BITS-1:0] word_index(input logic [AWIDTH-1:0] addr);
        return IDX_BITS'((addr - BASE) >> LANE_BITS);
    endfunction

`ifdef RVEE_AXIL_RAM_ERR_EN
    localparam longint unsigned WIN_BYTES = 64'(DEPTH) * 64'(STRB_W);

    function automatic logic in_window(input logic [AWIDTH-1:0] addr);
        return (addr >= BASE) && (64'(addr - BASE) < WIN_BYTES);
    endfunction
`endif

    // ---------------- write channel ----------------
    w_state_e            w_state, w_next;
    logic [AWIDTH-1:0]   aw_addr_q;
    logic [DWIDTH-1:0]   w_data_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [1:0]          bresp_q;
    logic                aw_hs, w_hs, commit, commit_err;
    logic [AWIDTH-1:0]   commit_addr;
    logic [DWIDTH-1:0]   commit_data;
    logic [STRB_W-1:0]   commit_strb;

    assign bus.awready = !rst && (w_state == W_IDLE || w_state == W_HAVE_W);
    assign bus.wready  = !rst && (w_state == W_IDLE || w_state == W_HAVE_AW);
    assign aw_hs       = bus.awvalid && bus.awready;
    assign w_hs        = bus.wvalid && bus.wready;

    // The commit takes whichever half arrives now and the latched copy of the other half.
    always_comb begin
        w_next      = w_state;
        commit      = 1'b0;
        commit_addr = bus.awaddr;
        commit_data = bus.wdata;
        commit_strb = bus.wstrb;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end else if (aw_hs) begin
                    w_next = W_HAVE_AW;
                end else if (w_hs) begin
                    w_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                commit_addr = aw_addr_q;
                if (w_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                commit_data = w_data_q;
                commit_strb = w_strb_q;
                if (aw_hs) begin
                    commit = 1'b1;
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (bus.bready) begin
                    w_next = W_IDLE;
                end
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            bresp_q <= RESP_OKAY;
        end else begin
            w_state <= w_next;
            if (commit) begin
                bresp_q <= commit_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Payload latches are only consumed after the FSM has recorded them as valid.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            aw_addr_q <= bus.awaddr;
        end
        if (w_hs) begin
            w_data_q <= bus.wdata;
            w_strb_q <= bus.wstrb;
        end
    end

    assign bus.bvalid = (w_state == W_RESP);
    assign bus.bresp  = bresp_q;

    // ---------------- read channel ----------------
    r_state_e            r_state, r_next;
    logic                ar_hs, rd_err, rerr_q;
    logic [1:0]          rresp_q;
    logic [DWIDTH-1:0]   ram_rdata;

    assign bus.arready = !rst && (r_state == R_IDLE);
    assign ar_hs       = bus.arvalid && bus.arready;

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs)      r_next = R_RESP;
            R_RESP:  if (bus.rready) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            rresp_q <= RESP_OKAY;
            rerr_q  <= 1'b0;
        end else begin
            r_state <= r_next;
            if (ar_hs) begin
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
                rerr_q  <= rd_err;
            end
        end
    end

    assign bus.rvalid = (r_state == R_RESP);
    assign bus.rresp  = rresp_q;
    assign bus.rdata  = rerr_q ? '0 : ram_rdata;

`ifdef RVEE_AXIL_RAM_ERR_EN
    assign commit_err = !in_window(commit_addr);
    assign rd_err     = !in_window(bus.araddr);
`else
    assign commit_err = 1'b0;
    assign rd_err     = 1'b0;
`endif

    rvee_ram_2p #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (commit && !commit_err),
        .waddr (word_index(commit_addr)),
        .wdata (commit_data),
        .wstrb (commit_strb),
        .re    (ar_hs),
        .raddr (word_index(bus.araddr)),
        .rdata (ram_rdata)
    );

    logic unused_prot;
    assign unused_prot = ^{bus.awprot, bus.arprot};

endmodule : rvee_axil_ram

// File: doc/rvee_axil_ram.md
RVEE_AXIL_RAM -- requirements
Module: rvee_axil_ram

Interface
REQ-001 SHALL have parameter AWIDTH, default 32, AXI address width.
REQ-002 SHALL have parameter DWIDTH, default 32, AXI data width (32 or 64).
REQ-003 SHALL have parameter DEPTH, default 1024, RAM depth in DWIDTH words, power of two.
REQ-004 SHALL have parameter BASE, default 0, byte base address of the RAM window.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have ports awvalid in 1, awready out 1, awaddr in AWIDTH, awprot in 3 (ignored).
REQ-008 SHALL have ports wvalid in 1, wready out 1, wdata in DWIDTH, wstrb in DWIDTH/8.
REQ-009 SHALL have ports bvalid out 1, bready in 1, bresp out 2.
REQ-010 SHALL have ports arvalid in 1, arready out 1, araddr in AWIDTH, arprot in 3 (ignored).
REQ-011 SHALL have ports rvalid out 1, rready in 1, rdata out DWIDTH, rresp out 2.

Function
REQ-012 SHALL act as AXI4-Lite responder; word index = (addr - BASE) >> log2(DWIDTH/8), low byte-lane bits ignored.
REQ-013 SHALL run a write FSM: W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP.
REQ-014 SHALL drive awready high in W_IDLE/W_HAVE_W and wready high in W_IDLE/W_HAVE_AW, low elsewhere.
REQ-015 SHALL in W_IDLE: AW+W same cycle -> W_RESP; AW only -> W_HAVE_AW (latch addr); W only -> W_HAVE_W (latch data, strb).
REQ-016 SHALL commit the write at the edge where the second of AW/W handshakes completes, updating only bytes with wstrb set.
REQ-017 SHALL assert bvalid the cycle after commit, hold bvalid/bresp stable until bready, then return to W_IDLE.
REQ-018 SHALL run a read FSM: R_IDLE (arready=1), R_RESP (arready=0).
REQ-019 SHALL on AR handshake present rdata/rresp with rvalid the next cycle, hold stable until rready, then R_IDLE; throughput one read per two cycles minimum.
REQ-020 SHALL give a read sampled in the same cycle as a write commit to the same word the pre-write data.
REQ-021 SHALL run read and write channels independently; neither blocks the other.
REQ-022 SHALL set bresp/rresp to OKAY (2'b00) for all accesses unless REQ-026 applies.

Reset
REQ-023 SHALL on rst force both FSMs to idle, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
REQ-024 SHALL hold awready, wready, arready low while rst is high.
REQ-025 SHALL discard any half-received write at reset (no commit); RAM contents are not reset.

Configuration
REQ-026 SHALL with RVEE_AXIL_RAM_ERR_EN defined: address outside [BASE, BASE+DEPTH*DWIDTH/8) -> SLVERR (2'b10), write suppressed, rdata=0.
REQ-027 SHALL without RVEE_AXIL_RAM_ERR_EN: index wraps modulo DEPTH, always OKAY.

Structure
REQ-028 SHALL take response codes (RESP_OKAY, RESP_SLVERR) and FSM state enums from shared package rvee_axil_pkg.
REQ-029 SHALL instantiate storage as sub-module rvee_ram_2p (1 write port with byte enables, 1 synchronous read port).

Verification
REQ-030 SHALL cover: AW+W same cycle addr 0x10 data 0xDEADBEEF strb 0xF -> bvalid next cycle, OKAY; read 0x10 -> 0xDEADBEEF.
REQ-031 SHALL cover: W 3 cycles before AW (addr 0x20, data 0x11223344) -> commit on AW, read returns 0x11223344.
REQ-032 SHALL cover: strb 0x2 data 0xAABBCCDD over 0x11223344 at 0x20 -> read 0x1122CC44.
REQ-033 SHALL cover: bready/rready held low 5 cycles -> bvalid/rvalid, bresp, rdata stable, awready/arready low throughout.
REQ-034 SHALL cover: rst asserted in W_HAVE_AW -> no commit, all valids 0, readies low during rst, high the cycle after.
REQ-035 SHALL cover with RVEE_AXIL_RAM_ERR_EN: write/read at BASE+0x1000 (DEPTH 1024) -> SLVERR, rdata 0, RAM unchanged; without macro, aliases word 0.
